dmem_bus_ctrl: RTL and testbench
================================

// Module: dmem_bus_ctrl
// PURPOSE
//   Data-memory access controller downstream of the single-cycle RISC-V core's load/store path.
//   Converts the core's lw/sw request into a req/gnt/rvalid handshake on a multi-cycle data bus.
//   Returns load data to the core and holds the core in stall until the access completes.
//   Per-access bus timeout; errors flagged to the core.
// PARAMETERS
//   TIMEOUT_CYCLES  16            cycles in REQ or WAIT without progress before abort; 1..255
//   ERR_DATA        32'hDEADBEEF  core_rdata value returned on an aborted or trapped access
// PORTS
//   clk         in   1   single clock, rising edge
//   reset       in   1   asynchronous, active-low reset: 0 = in reset
//   core_req    in   1   core wants a data access this instruction (lw or sw)
//   core_we     in   1   1 = store (core MemWrite), 0 = load
//   core_addr   in   32  byte address (core ALUResult)
//   core_wdata  in   32  store data (core WriteData)
//   core_rdata  out  32  load data (core ReadData), valid in DONE
//   core_stall  out  1   1 = core must hold PC and architectural state
//   core_err    out  1   1 in DONE if the access was aborted or trapped
//   bus_req     out  1   bus request, registered
//   bus_we      out  1   bus write strobe, registered
//   bus_addr    out  32  bus word address, registered
//   bus_wdata   out  32  bus write data, registered
//   bus_gnt     in   1   request accepted by the bus this cycle
//   bus_rvalid  in   1   bus_rdata valid this cycle
//   bus_rdata   in   32  bus read data
// BEHAVIOUR
//   Reset (async, reset==0): state=IDLE; bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0;
//     core_rdata=0, core_err=0, timeout counter=0. Mid-access reset drops bus_req immediately.
//   FSM states: IDLE, REQ, WAIT, DONE.
//   IDLE: on core_req=1, latch we/addr/wdata into bus regs, set bus_req, go REQ.
//     Later changes on core_* inputs are ignored until DONE.
//   REQ: bus_req/bus_we/bus_addr/bus_wdata held stable until bus_gnt=1.
//     gnt & store -> DONE. gnt & load & !rvalid -> WAIT. gnt & load & rvalid -> DONE with rdata captured.
//     bus_req drops on the edge that leaves REQ.
//   WAIT: bus_rvalid=1 -> capture bus_rdata into core_rdata, go DONE. rvalid outside WAIT/REQ is ignored.
//   DONE: lasts exactly one cycle, then IDLE. core_req in DONE does not start a new access
//     (the core retires the instruction on this edge). The next access starts from IDLE.
//   core_stall (combinational) = core_req & (state != DONE); 0 whenever core_req=0.
//   core_err: set on entry to DONE for an abort; cleared on entry to DONE for a clean
//     access and on reset. core_rdata holds its value outside DONE.
//   Timeout: counter cleared on entry to REQ and to WAIT; increments each cycle there.
//     Reaching TIMEOUT_CYCLES -> DONE, core_err=1, core_rdata=ERR_DATA, bus_req dropped.
//     A gnt/rvalid arriving on the same edge as the timeout wins (normal completion).
//   Minimum latency: store with immediate gnt = 2 stall cycles (IDLE, REQ), then DONE.
//     Load with gnt+rvalid together = 2 stall cycles; otherwise stall = 2 + WAIT cycles.
//   Data width fixed at 32 bits; word accesses only, no byte enables.
// CONFIGURATION
//   MISALIGN_TRAP_EN defined: core_addr[1:0]!=0 in IDLE -> no bus request.
//     Go DONE next cycle with core_err=1 and core_rdata=ERR_DATA.
//   MISALIGN_TRAP_EN undefined: no trap. bus_addr = {core_addr[31:2],2'b00}, and the access proceeds normally.
// TESTING
//   Store 0x1234_5678 @0x100, gnt next cycle -> bus_we=1, bus_addr=0x100, stall 2 cycles, core_err=0.
//   Load @0x200, gnt after 3 cycles, rvalid 2 later with 0xCAFE_F00D -> core_rdata=0xCAFE_F00D in DONE, bus_req 1 only in REQ.
//   Load, gnt+rvalid same cycle with 0x0000_00FF -> DONE next cycle, 2 stall cycles.
//   Load, gnt never asserted -> after 16 REQ cycles DONE: core_err=1, core_rdata=0xDEADBEEF, bus_req=0.
//   Reset pulled low while in WAIT -> bus_req=0, state IDLE, outputs zero; later rvalid ignored.
//   Load @0x203 with MISALIGN_TRAP_EN -> bus_req never 1, core_err=1; without the macro -> bus_addr=0x200.

Source files
------------

// File: rtl/dmem_bus_ctrl.sv
// Load/store bridge from the core's data port to a req/gnt/rvalid bus, with a per-access timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned core addresses are trapped without a bus request.
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic        core_err_q, core_err_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        misaligned;
    logic        tmo_hit;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (core_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        core_rdata_d = core_rdata_q;
        core_err_d   = core_err_q;
        tmo_cnt_d    = tmo_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (core_req) begin
                    if (misaligned) begin
                        state_d      = S_DONE;
                        core_err_d   = 1'b1;
                        core_rdata_d = ERR_DATA;
                    end else begin
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = core_we;
                        bus_addr_d  = core_addr & 32'hFFFF_FFFC;
                        bus_wdata_d = core_wdata;
                        tmo_cnt_d   = 8'd0;
                    end
                end
            end
            S_REQ: begin
                // Progress on the bus takes priority over a timeout on the same edge.
                if (bus_gnt) begin
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d    = S_DONE;
                        core_err_d = 1'b0;
                    end else if (bus_rvalid) begin
                        state_d      = S_DONE;
                        core_err_d   = 1'b0;
                        core_rdata_d = bus_rdata;
                    end else begin
                        state_d   = S_WAIT;
                        tmo_cnt_d = 8'd0;
                    end
                end else if (tmo_hit) begin
                    state_d      = S_DONE;
                    bus_req_d    = 1'b0;
                    core_err_d   = 1'b1;
                    core_rdata_d = ERR_DATA;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d      = S_DONE;
                    core_err_d   = 1'b0;
                    core_rdata_d = bus_rdata;
                end else if (tmo_hit) begin
                    state_d      = S_DONE;
                    core_err_d   = 1'b1;
                    core_rdata_d = ERR_DATA;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            default: begin
                // The core retires on this edge, so a held core_req must not relaunch here.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'd0;
            bus_wdata_q  <= 32'd0;
            core_rdata_q <= 32'd0;
            core_err_q   <= 1'b0;
            tmo_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            core_rdata_q <= core_rdata_d;
            core_err_q   <= core_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign core_stall = core_req & (state_q != S_DONE);
    assign core_rdata = core_rdata_q;
    assign core_err   = core_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: stores, loads, timeouts, mid-access reset, misaligned address.
module tb_dmem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    dmem_bus_ctrl #(
        .TIMEOUT_CYCLES(16),
        .ERR_DATA      (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .core_req  (core_req),
        .core_we   (core_we),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .core_err  (core_err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_gnt   (bus_gnt),
        .bus_rvalid(bus_rvalid),
        .bus_rdata (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic rq, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic g, input logic rv, input logic [31:0] rd);
        core_req   = rq;
        core_we    = we;
        core_addr  = a;
        core_wdata = wd;
        bus_gnt    = g;
        bus_rvalid = rv;
        bus_rdata  = rd;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        #1 reset = 1'b0;
        #1;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_core_err", core_err, 0);
        chk("rst_core_stall", core_stall, 0);
        nxt();
        reset = 1'b1;

        // Store 0x12345678 @0x100, granted in the first REQ cycle
        drv(1, 1, 32'h100, 32'h1234_5678, 0, 0, 32'h0);
        @(negedge clk);
        chk("st_idle_stall", core_stall, 1);
        chk("st_idle_bus_req", bus_req, 0);
        nxt();
        drv(1, 1, 32'h100, 32'h1234_5678, 1, 0, 32'h0);
        @(negedge clk);
        chk("st_req_bus_req", bus_req, 1);
        chk("st_req_bus_we", bus_we, 1);
        chk("st_req_bus_addr", bus_addr, 32'h100);
        chk("st_req_bus_wdata", bus_wdata, 32'h1234_5678);
        chk("st_req_stall", core_stall, 1);
        nxt();
        drv(1, 1, 32'h100, 32'h1234_5678, 0, 0, 32'h0);
        @(negedge clk);
        chk("st_done_stall", core_stall, 0);
        chk("st_done_err", core_err, 0);
        chk("st_done_bus_req", bus_req, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("st_idle2_stall", core_stall, 0);
        nxt();

        // Load @0x200: gnt on the 3rd REQ cycle, rvalid 2 cycles later
        drv(1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
        nxt();
        drv(1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("ld_req1_bus_req", bus_req, 1);
        chk("ld_req1_bus_we", bus_we, 0);
        chk("ld_req1_bus_addr", bus_addr, 32'h200);
        nxt();
        drv(0, 1, 32'h999, 32'hFFFF_FFFF, 0, 0, 32'h0);
        @(negedge clk);
        chk("ld_req2_stall_noreq", core_stall, 0);
        chk("ld_req2_addr_held", bus_addr, 32'h200);
        chk("ld_req2_bus_req", bus_req, 1);
        nxt();
        drv(1, 0, 32'h200, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        chk("ld_req3_bus_req", bus_req, 1);
        chk("ld_req3_bus_we", bus_we, 0);
        chk("ld_req3_stall", core_stall, 1);
        nxt();
        drv(1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("ld_wait1_bus_req", bus_req, 0);
        chk("ld_wait1_stall", core_stall, 1);
        nxt();
        drv(1, 0, 32'h200, 32'h0, 0, 1, 32'hCAFE_F00D);
        @(negedge clk);
        chk("ld_wait2_stall", core_stall, 1);
        nxt();
        drv(1, 0, 32'h200, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("ld_done_stall", core_stall, 0);
        chk("ld_done_rdata", core_rdata, 32'hCAFE_F00D);
        chk("ld_done_err", core_err, 0);
        chk("ld_done_bus_req", bus_req, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        nxt();

        // Load with gnt and rvalid together; stray rvalid afterwards is ignored
        drv(1, 0, 32'h204, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("fast_idle_stall", core_stall, 1);
        nxt();
        drv(1, 0, 32'h204, 32'h0, 1, 1, 32'h0000_00FF);
        @(negedge clk);
        chk("fast_req_stall", core_stall, 1);
        chk("fast_req_bus_req", bus_req, 1);
        nxt();
        drv(1, 0, 32'h204, 32'h0, 0, 1, 32'h0000_0055);
        @(negedge clk);
        chk("fast_done_stall", core_stall, 0);
        chk("fast_done_rdata", core_rdata, 32'h0000_00FF);
        chk("fast_done_err", core_err, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_0066);
        @(negedge clk);
        chk("fast_idle_no_relaunch", bus_req, 0);
        chk("fast_idle_stall", core_stall, 0);
        chk("fast_idle_rdata_held", core_rdata, 32'h0000_00FF);
        nxt();

        // Load, gnt never asserted: 16 REQ cycles then abort
        drv(1, 0, 32'h300, 32'h0, 0, 0, 32'h0);
        nxt();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("tmo_req%0d_bus_req", i), bus_req, 1);
            chk($sformatf("tmo_req%0d_stall", i), core_stall, 1);
            nxt();
        end
        @(negedge clk);
        chk("tmo_done_stall", core_stall, 0);
        chk("tmo_done_err", core_err, 1);
        chk("tmo_done_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("tmo_done_bus_req", bus_req, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        nxt();

        // gnt+rvalid on the 16th REQ cycle beats the timeout
        drv(1, 0, 32'h304, 32'h0, 0, 0, 32'h0);
        nxt();
        for (int i = 0; i < 15; i++) nxt();
        drv(1, 0, 32'h304, 32'h0, 1, 1, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("race_req16_bus_req", bus_req, 1);
        nxt();
        drv(1, 0, 32'h304, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("race_done_err", core_err, 0);
        chk("race_done_rdata", core_rdata, 32'hA5A5_A5A5);
        chk("race_done_stall", core_stall, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        nxt();

        // Load granted but rvalid never comes: 16 WAIT cycles then abort
        drv(1, 0, 32'h308, 32'h0, 0, 0, 32'h0);
        nxt();
        drv(1, 0, 32'h308, 32'h0, 1, 0, 32'h0);
        nxt();
        drv(1, 0, 32'h308, 32'h0, 0, 0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("wtmo_wait%0d_stall", i), core_stall, 1);
            nxt();
        end
        @(negedge clk);
        chk("wtmo_done_err", core_err, 1);
        chk("wtmo_done_rdata", core_rdata, 32'hDEAD_BEEF);
        chk("wtmo_done_stall", core_stall, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        nxt();

        // Reset asserted while in WAIT; later rvalid must be ignored
        drv(1, 0, 32'h400, 32'h0, 0, 0, 32'h0);
        nxt();
        drv(1, 0, 32'h400, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        chk("rw_req_bus_req", bus_req, 1);
        nxt();
        drv(1, 0, 32'h400, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("rw_wait_stall", core_stall, 1);
        #2 reset = 1'b0;
        #1;
        chk("rw_rst_bus_req", bus_req, 0);
        chk("rw_rst_bus_addr", bus_addr, 0);
        chk("rw_rst_rdata", core_rdata, 0);
        chk("rw_rst_err", core_err, 0);
        nxt();
        reset = 1'b1;
        drv(0, 0, 32'h0, 32'h0, 0, 1, 32'h0000_0077);
        @(negedge clk);
        chk("rw_after_rdata", core_rdata, 0);
        chk("rw_after_bus_req", bus_req, 0);
        chk("rw_after_stall", core_stall, 0);
        nxt();
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("rw_after2_rdata", core_rdata, 0);
        nxt();

        // Misaligned load @0x203
`ifdef MISALIGN_TRAP_EN
        drv(1, 0, 32'h203, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("mis_idle_stall", core_stall, 1);
        chk("mis_idle_bus_req", bus_req, 0);
        nxt();
        drv(1, 0, 32'h203, 32'h0, 1, 1, 32'h0000_0011);
        @(negedge clk);
        chk("mis_done_bus_req", bus_req, 0);
        chk("mis_done_stall", core_stall, 0);
        chk("mis_done_err", core_err, 1);
        chk("mis_done_rdata", core_rdata, 32'hDEAD_BEEF);
        nxt();
`else
        drv(1, 0, 32'h203, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("mis_idle_stall", core_stall, 1);
        nxt();
        drv(1, 0, 32'h203, 32'h0, 1, 1, 32'h0000_0011);
        @(negedge clk);
        chk("mis_req_bus_req", bus_req, 1);
        chk("mis_req_bus_addr", bus_addr, 32'h200);
        nxt();
        drv(1, 0, 32'h203, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        chk("mis_done_rdata", core_rdata, 32'h0000_0011);
        chk("mis_done_err", core_err, 0);
        chk("mis_done_stall", core_stall, 0);
        nxt();
`endif
        drv(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
